// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode encoding, opcode field positions and FSM states shared by
//          the serial ALU and its digit slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    localparam int AINV   = 3;
    localparam int BNEG   = 2;
    localparam int SEL_HI = 1;
    localparam int SEL_LO = 0;

    localparam logic [1:0] SEL_AND   = 2'b00;
    localparam logic [1:0] SEL_OR    = 2'b01;
    localparam logic [1:0] SEL_ADD   = 2'b10;
    localparam logic [1:0] SEL_PASSB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_digit.sv
// ============================================================================
// Module : alu_digit
// Brief  : Combinational DIGIT-bit ripple slice built from the one-bit ALU cell.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_in_i,
    input  logic [3:0]       opcode_i,
    output logic [DIGIT-1:0] result_o,
    output logic             c_out_o,
    output logic             c_msb_in_o
);

    logic [DIGIT-1:0] a_mod;
    logic [DIGIT-1:0] b_mod;
    logic [1:0]       sel;

    assign a_mod = opcode_i[AINV] ? ~a_i : a_i;
    assign b_mod = opcode_i[BNEG] ? ~b_i : b_i;
    assign sel   = opcode_i[SEL_HI:SEL_LO];

    // The carry chain ripples for every opcode so the flags are always defined.
    always_comb begin
        logic c;
        result_o   = '0;
        c_msb_in_o = 1'b0;
        c          = c_in_i;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in_o = c;
            end
            case (sel)
                SEL_AND: result_o[i] = a_mod[i] & b_mod[i];
                SEL_OR:  result_o[i] = a_mod[i] | b_mod[i];
                SEL_ADD: result_o[i] = a_mod[i] ^ b_mod[i] ^ c;
                default: result_o[i] = b_mod[i];
            endcase
            c = (a_mod[i] & b_mod[i]) | (a_mod[i] & c) | (b_mod[i] & c);
        end
        c_out_o = c;
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial.sv
// ============================================================================
// Module : alu_serial
// Brief  : Digit-serial WIDTH-bit ALU with start/done handshake, carry, zero
//          and signed-overflow flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       opcode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             c_out_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_digit_check
            $error("alu_serial: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
        end
    endgenerate

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_sh_q;
    logic [3:0]         op_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               c_out_q;
    logic               zero_q;
    logic               overflow_q;

    logic [DIGIT-1:0]   dig_res;
    logic               dig_cout;
    logic               dig_cmsb;
    logic [WIDTH-1:0]   res_sh_d;
    logic               last_dig;

    alu_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_i       (a_sh_q[DIGIT-1:0]),
        .b_i       (b_sh_q[DIGIT-1:0]),
        .c_in_i    (carry_q),
        .opcode_i  (op_q),
        .result_o  (dig_res),
        .c_out_o   (dig_cout),
        .c_msb_in_o(dig_cmsb)
    );

    // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
    assign res_sh_d = (res_sh_q >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
    assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            op_q       <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            c_out_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        op_q    <= opcode_i;
                        carry_q <= opcode_i[BNEG];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> DIGIT;
                    b_sh_q   <= b_sh_q >> DIGIT;
                    res_sh_q <= res_sh_d;
                    carry_q  <= dig_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_dig) begin
                        result_q   <= res_sh_d;
                        c_out_q    <= dig_cout;
                        zero_q     <= (res_sh_d == '0);
                        overflow_q <= dig_cmsb ^ dig_cout;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= FIN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign c_out_o    = c_out_q;
    assign zero_o     = zero_q;
    assign overflow_o = overflow_q;

endmodule

`default_nettype wire
